// File: rtl/st_delay_line_pkg.sv
// Shared types for the Avalon-ST delay line: the stream beat and the
// framing tracker state.
package st_delay_line_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        valid;
  } avln_st;

  typedef enum logic {
    DL_IDLE     = 1'b0,
    DL_IN_FRAME = 1'b1
  } dl_state_e;

  localparam int AVLN_W = $bits(avln_st);

endpackage

// File: rtl/st_delay_line_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the new data,
// which keeps the shortest legal delay exact.
module st_delay_line_sdp_ram #(
  parameter int WIDTH  = 37,
  parameter int ADDR_W = 7
) (
  input  logic              sys_clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

`ifdef ICARUS
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
  end
`endif

  // Store one entry per enabled cycle.
  always_ff @(posedge sys_clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Registered read with write-through on address collision.
  always_ff @(posedge sys_clk) begin
    if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
    else                              rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/st_delay_line.sv
// Fixed-latency Avalon-ST delay line. Every cycle's input beat is written to a
// circular buffer and re-emerges exactly DELAY cycles later. Framing on the
// input is tracked to count frames and framing errors, and beats that arrive
// outside a frame can be scrubbed to valid=0 before storage.
module st_delay_line
  import st_delay_line_pkg::*;
#(
  parameter int DELAY  = 64,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 32,
  parameter bit SCRUB  = 1'b1
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  avln_st           in,
  input  logic             clear_stats,
  output avln_st           out,
  output logic             primed,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_no_eop,
  output logic [CNT_W-1:0] err_orphan
);

  if (DELAY < 2 || DELAY > (2**ADDR_W) - 1) begin : g_bad_delay
    $error("st_delay_line: DELAY must satisfy 2 <= DELAY <= 2**ADDR_W-1");
  end

  // Read trails write by DELAY-2; RAM read register plus out register add 2.
  localparam logic [ADDR_W-1:0] RD_OFS   = ADDR_W'(DELAY - 2);
  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DELAY);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              primed_q, primed_d;
  avln_st            out_q, out_d;
  avln_st            in_clean, rd_data;
  dl_state_e         state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q, no_eop_q, orphan_q;
  logic              ev_frame, ev_no_eop, ev_orphan;

  // Framing decode on valid input beats and the scrub mux.
  always_comb begin
    ev_frame  = in.valid && in.sop;
    ev_no_eop = in.valid && in.sop && (state_q == DL_IN_FRAME);
    ev_orphan = in.valid && !in.sop && (state_q == DL_IDLE);
    state_d   = state_q;
    if (in.valid) begin
      if (in.sop)      state_d = in.eop ? DL_IDLE : DL_IN_FRAME;
      else if (in.eop) state_d = DL_IDLE;
    end
    in_clean = in;
    if (SCRUB && ev_orphan) in_clean.valid = 1'b0;
  end

  // Pointer, fill level and output gating next-state.
  always_comb begin
    wptr_d   = wptr_q + 1'b1;
    rptr     = wptr_q - RD_OFS;
    fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    primed_d = (fill_d == FILL_MAX);
    out_d    = primed_d ? rd_data : '0;
  end

  st_delay_line_sdp_ram #(
    .WIDTH  (AVLN_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .sys_clk (sys_clk),
    .we_i    (1'b1),
    .waddr_i (wptr_q),
    .wdata_i (in_clean),
    .raddr_i (rptr),
    .rdata_o (rd_data)
  );

  // Write pointer, fill/primed tracking and the gated output register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      out_q    <= '0;
    end else begin
      wptr_q   <= wptr_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      out_q    <= out_d;
    end
  end

  // Framing FSM and saturating statistics; clear wins over any increment.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= DL_IDLE;
      frame_cnt_q <= '0;
      no_eop_q    <= '0;
      orphan_q    <= '0;
    end else begin
      state_q <= state_d;
      if (clear_stats) begin
        frame_cnt_q <= '0;
        no_eop_q    <= '0;
        orphan_q    <= '0;
      end else begin
        frame_cnt_q <= sat_inc(frame_cnt_q, ev_frame);
        no_eop_q    <= sat_inc(no_eop_q, ev_no_eop);
        orphan_q    <= sat_inc(orphan_q, ev_orphan);
      end
    end
  end

  assign out        = out_q;
  assign primed     = primed_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_no_eop = no_eop_q;
  assign err_orphan = orphan_q;

endmodule

// File: tb/tb_st_delay_line.sv
// Bench for st_delay_line: a scrubbing and a non-scrubbing instance share one
// input stream; a cycle-history model predicts both outputs and the counters.
module tb_st_delay_line;
  import st_delay_line_pkg::*;

  localparam int DELAY  = 64;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 32;
  localparam int HW     = 256;
  localparam int PAD    = 64 - $bits(avln_st);

  logic             sys_clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear_stats = 1'b0;
  avln_st           in_s = '0;
  avln_st           out_s, out0_s;
  logic             primed, primed0;
  logic [CNT_W-1:0] fc, ne, eo, fc0, ne0, eo0;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 1'b0;

  always #5 sys_clk = ~sys_clk;

  st_delay_line #(.DELAY(DELAY), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .SCRUB(1'b1)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .in(in_s), .clear_stats(clear_stats),
    .out(out_s), .primed(primed), .frame_cnt(fc), .err_no_eop(ne), .err_orphan(eo));

  st_delay_line #(.DELAY(DELAY), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .SCRUB(1'b0)) dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n), .in(in_s), .clear_stats(clear_stats),
    .out(out0_s), .primed(primed0), .frame_cnt(fc0), .err_no_eop(ne0), .err_orphan(eo0));

  function automatic logic [63:0] xb(input avln_st b);
    return {{PAD{1'b0}}, b};
  endfunction

  function automatic logic [63:0] xc(input logic [CNT_W-1:0] v);
    return {{(64-CNT_W){1'b0}}, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of stored beats indexed by cycle since reset release.
  int     m_cyc;
  bit     m_inf;
  int     m_fc, m_ne, m_eo;
  avln_st hist_s [HW];
  avln_st hist_u [HW];

  always @(posedge sys_clk or negedge reset_n) begin : mdl
    avln_st b, s;
    bit     inf;
    int     f, n, o;
    if (!reset_n) begin
      m_cyc <= 0; m_inf <= 1'b0; m_fc <= 0; m_ne <= 0; m_eo <= 0;
    end else begin
      b = in_s; s = in_s; inf = m_inf; f = m_fc; n = m_ne; o = m_eo;
      if (b.valid) begin
        if (b.sop) begin
          f++;
          if (inf) n++;
          inf = !b.eop;
        end else if (!inf) begin
          o++;
          s.valid = 1'b0;
        end else if (b.eop) begin
          inf = 1'b0;
        end
      end
      if (clear_stats) begin f = 0; n = 0; o = 0; end
      hist_s[m_cyc % HW] <= s;
      hist_u[m_cyc % HW] <= b;
      m_cyc <= m_cyc + 1;
      m_inf <= inf; m_fc <= f; m_ne <= n; m_eo <= o;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge sys_clk) begin : cmp
    avln_st es, eu;
    if (chk_en) begin
      es = '0; eu = '0;
      if (m_cyc >= DELAY) begin
        es = hist_s[(m_cyc - DELAY) % HW];
        eu = hist_u[(m_cyc - DELAY) % HW];
      end
      check("out",        xb(out_s),  xb(es));
      check("out_noscrub", xb(out0_s), xb(eu));
      check("primed",     {63'b0, primed},  {63'b0, (m_cyc >= DELAY)});
      check("primed0",    {63'b0, primed0}, {63'b0, (m_cyc >= DELAY)});
      check("frame_cnt",  xc(fc), 64'(m_fc));
      check("err_no_eop", xc(ne), 64'(m_ne));
      check("err_orphan", xc(eo), 64'(m_eo));
      check("frame_cnt0", xc(fc0), 64'(m_fc));
      check("err_no_eop0", xc(ne0), 64'(m_ne));
      check("err_orphan0", xc(eo0), 64'(m_eo));
    end
  end

  function automatic avln_st mk(input logic [31:0] d, input logic sop,
                                input logic eop, input logic vld);
    avln_st b;
    b.data = d; b.sop = sop; b.eop = eop; b.empty = eop ? 2'd1 : 2'd0; b.valid = vld;
    return b;
  endfunction

  int run_cyc = 0;

  task automatic drive(input avln_st b, input logic clr);
    in_s = b; clear_stats = clr;
    @(posedge sys_clk); #1;
    run_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk($urandom, 1'b0, 1'b0, 1'b0), 1'b0);
  endtask

  initial begin
    int nfr, len;
    avln_st r;
    #3 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge sys_clk);
    check("rst_out", xb(out_s), 64'd0);
    check("rst_primed", {63'b0, primed}, 64'd0);
    check("rst_frame_cnt", xc(fc), 64'd0);
    @(posedge sys_clk); #1 reset_n = 1'b1;

    // 3-beat frame at cycle 0; first beat emerges at cycle 64.
    drive(mk(32'hAAAA0001, 1'b1, 1'b0, 1'b1), 1'b0);
    drive(mk(32'hAAAA0002, 1'b0, 1'b0, 1'b1), 1'b0);
    drive(mk(32'hAAAA0003, 1'b0, 1'b1, 1'b1), 1'b0);
    idle(60);
    @(negedge sys_clk);
    check("p1_primed_lo", {63'b0, primed}, 64'd0);
    check("p1_out_quiet", xb(out_s), 64'd0);
    idle(1);
    @(negedge sys_clk);
    check("p1_sop", {63'b0, out_s.sop}, 64'd1);
    check("p1_data0", {32'b0, out_s.data}, 64'hAAAA0001);
    check("p1_primed_hi", {63'b0, primed}, 64'd1);
    idle(2);
    @(negedge sys_clk);
    check("p1_eop", {63'b0, out_s.eop}, 64'd1);
    check("p1_data2", {32'b0, out_s.data}, 64'hAAAA0003);

    // Back-to-back random frames well past pointer wrap.
    drive(mk(0, 1'b0, 1'b0, 1'b0), 1'b1);
    nfr = 0; run_cyc = 0;
    while (run_cyc < 1000) begin
      len = $urandom_range(1, 6);
      nfr++;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) drive(mk($urandom, 1'b0, 1'b0, 1'b0), 1'b0);
        drive(mk($urandom, (i == 0), (i == len - 1), 1'b1), 1'b0);
      end
    end
    @(negedge sys_clk);
    check("p2_frame_cnt", xc(fc), 64'(nfr));
    check("p2_no_err", xc(ne | eo), 64'd0);

    // Ten single-beat frames.
    drive(mk(0, 1'b0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 10; i++) drive(mk(32'h5000 + i, 1'b1, 1'b1, 1'b1), 1'b0);
    @(negedge sys_clk);
    check("p3_frame_cnt", xc(fc), 64'd10);
    check("p3_no_eop", xc(ne), 64'd0);
    check("p3_orphan", xc(eo), 64'd0);

    // Missing eop: sop, data, sop, eop.
    drive(mk(0, 1'b0, 1'b0, 1'b0), 1'b1);
    drive(mk(32'h1, 1'b1, 1'b0, 1'b1), 1'b0);
    drive(mk(32'h2, 1'b0, 1'b0, 1'b1), 1'b0);
    drive(mk(32'h3, 1'b1, 1'b0, 1'b1), 1'b0);
    drive(mk(32'h4, 1'b0, 1'b1, 1'b1), 1'b0);
    @(negedge sys_clk);
    check("p4_no_eop", xc(ne), 64'd1);
    check("p4_frame_cnt", xc(fc), 64'd2);

    // Orphan beat (also proves the tracker returned to idle).
    drive(mk(32'hC0FFEE00, 1'b0, 1'b0, 1'b1), 1'b0);
    @(negedge sys_clk);
    check("p5_orphan", xc(eo), 64'd1);
    idle(63);
    @(negedge sys_clk);
    check("p5_scrub_valid", {63'b0, out_s.valid}, 64'd0);
    check("p5_raw_valid", {63'b0, out0_s.valid}, 64'd1);
    check("p5_data", {32'b0, out_s.data}, 64'hC0FFEE00);

    // Reset mid-frame, then a fresh frame.
    drive(mk(32'hDEAD0001, 1'b1, 1'b0, 1'b1), 1'b0);
    drive(mk(32'hDEAD0002, 1'b0, 1'b0, 1'b1), 1'b0);
    reset_n = 1'b0;
    #1;
    check("p6_rst_out", xb(out_s), 64'd0);
    check("p6_rst_primed", {63'b0, primed}, 64'd0);
    check("p6_rst_fc", xc(fc), 64'd0);
    @(posedge sys_clk); #1 reset_n = 1'b1;
    drive(mk(32'hBEEF0001, 1'b1, 1'b0, 1'b1), 1'b0);
    drive(mk(32'hBEEF0002, 1'b0, 1'b0, 1'b1), 1'b0);
    drive(mk(32'hBEEF0003, 1'b0, 1'b1, 1'b1), 1'b0);
    idle(60);
    @(negedge sys_clk);
    check("p6_quiet", xb(out_s), 64'd0);
    idle(1);
    @(negedge sys_clk);
    check("p6_sop", {63'b0, out_s.sop}, 64'd1);
    check("p6_data", {32'b0, out_s.data}, 64'hBEEF0001);

    // Clear together with an error: clear wins.
    drive(mk(32'h77, 1'b0, 1'b0, 1'b1), 1'b1);
    @(negedge sys_clk);
    check("p6_clr_prio", xc(eo), 64'd0);
    drive(mk(32'h78, 1'b0, 1'b0, 1'b1), 1'b0);
    @(negedge sys_clk);
    check("p6_after_clr", xc(eo), 64'd1);

    // Unconstrained random traffic including occasional clears.
    for (int i = 0; i < 600; i++) begin
      r = avln_st'({$urandom, 5'($urandom)});
      drive(r, ($urandom_range(0, 19) == 0));
    end
    idle(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
